// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
//   RATIO_W_DEF : default width of one channel's ratio field
//   BYPASS_MAX  : largest ratio that still means "pass the reference clock through"
//   half_high() : length of the high phase for a ratio, rounded up so odd ratios
//                 spend the extra cycle high
`timescale 1ns/1ps
package clk_div_pkg;

  localparam int unsigned RATIO_W_DEF = 8;
  localparam int unsigned BYPASS_MAX  = 1;

  // Evaluated in 32 bits so a full-scale ratio (e.g. 255) cannot wrap the +1.
  function automatic int unsigned half_high(input int unsigned ratio);
    return (ratio + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: active/pending ratio registers, load/ack handshake,
// period counter and the output mux between divided clock and reference.
// Ports:
//   i_ref_clk    reference clock, all state on its rising edge
//   i_rst        asynchronous active-high reset
//   i_clk_en     channel enable; low forces reference passthrough
//   i_div_ratio  requested ratio, sampled when i_ratio_load is high
//   i_ratio_load one-cycle strobe capturing i_div_ratio
//   o_div_clk    divided clock, or i_ref_clk in bypass
//   o_div_tick   high for the first reference cycle of every divided period
//   o_ratio_ack  one-cycle pulse when a loaded ratio becomes active
`timescale 1ns/1ps
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_W = RATIO_W_DEF
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_clk_en,
  input  logic [RATIO_W-1:0] i_div_ratio,
  input  logic               i_ratio_load,
  output logic               o_div_clk,
  output logic               o_div_tick,
  output logic               o_ratio_ack
);

  localparam logic [RATIO_W-1:0] ByMax = RATIO_W'(BYPASS_MAX);
  localparam logic [RATIO_W-1:0] One   = RATIO_W'(1);

  logic [RATIO_W-1:0] r_act_q, r_act_d;
  logic [RATIO_W-1:0] r_pend_q, r_pend_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic               pend_valid_q, pend_valid_d;
  logic               div_q, div_d;
  logic               run_q, run_d;  // divide mode active (registered so entry is edge-aligned)
  logic               ack_q, ack_d;

  logic [RATIO_W-1:0] high_len;
  logic [RATIO_W-1:0] apply_ratio;
  logic               boundary;
  logic               apply;

  assign high_len = RATIO_W'(half_high(32'(r_act_q)));

  always_comb begin
    boundary     = 1'b0;
    // run_q implies r_act_q >= 2, so the decrement never underflows.
    if (run_q) boundary = (cnt_q == r_act_q - One);

    // Divide mode applies only at a period boundary; bypass applies on the next edge.
    apply        = run_q ? (boundary && (pend_valid_q || i_ratio_load)) : pend_valid_q;
    // A load arriving on the apply edge is newer than the pending value, so it wins.
    apply_ratio  = i_ratio_load ? i_div_ratio : r_pend_q;

    r_act_d      = r_act_q;
    r_pend_d     = r_pend_q;
    pend_valid_d = pend_valid_q;
    if (apply) begin
      r_act_d      = apply_ratio;
      pend_valid_d = 1'b0;
    end else if (i_ratio_load) begin
      r_pend_d     = i_div_ratio;
      pend_valid_d = 1'b1;
    end
    ack_d = apply;

    if (!i_clk_en || (r_act_d <= ByMax)) begin
      run_d = 1'b0;
      cnt_d = '0;
      div_d = 1'b0;
    end else if (!run_q || apply) begin
      // Fresh period: enable rising or new ratio taking effect.
      run_d = 1'b1;
      cnt_d = '0;
      div_d = 1'b1;
    end else begin
      run_d = 1'b1;
      cnt_d = boundary ? '0 : cnt_q + One;
      div_d = (cnt_d < high_len);
    end
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act_q      <= '0;
      r_pend_q     <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      div_q        <= 1'b0;
      run_q        <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      r_act_q      <= r_act_d;
      r_pend_q     <= r_pend_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      run_q        <= run_d;
      ack_q        <= ack_d;
    end
  end

  assign o_div_clk   = run_q ? div_q : i_ref_clk;
  assign o_div_tick  = run_q && (cnt_q == '0);
  assign o_ratio_ack = ack_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: NUM_CH independent clk_div_ch instances
// sharing one reference clock and reset.
// Ports:
//   i_ref_clk, i_rst          reference clock and asynchronous active-high reset
//   i_clk_en[NUM_CH]          per-channel enable
//   i_div_ratio               per-channel ratios, channel k at [k*RATIO_W +: RATIO_W]
//   i_ratio_load[NUM_CH]      per-channel load strobe
//   o_div_clk[NUM_CH]         divided clocks (or reference passthrough)
//   o_div_tick[NUM_CH]        period-start pulses
//   o_ratio_ack[NUM_CH]       ratio-applied pulses
`timescale 1ns/1ps
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned RATIO_W = RATIO_W_DEF
) (
  input  logic                      i_ref_clk,
  input  logic                      i_rst,
  input  logic [NUM_CH-1:0]         i_clk_en,
  input  logic [NUM_CH*RATIO_W-1:0] i_div_ratio,
  input  logic [NUM_CH-1:0]         i_ratio_load,
  output logic [NUM_CH-1:0]         o_div_clk,
  output logic [NUM_CH-1:0]         o_div_tick,
  output logic [NUM_CH-1:0]         o_ratio_ack
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_ch #(
      .RATIO_W(RATIO_W)
    ) u_ch (
      .i_ref_clk   (i_ref_clk),
      .i_rst       (i_rst),
      .i_clk_en    (i_clk_en[k]),
      .i_div_ratio (i_div_ratio[k*RATIO_W +: RATIO_W]),
      .i_ratio_load(i_ratio_load[k]),
      .o_div_clk   (o_div_clk[k]),
      .o_div_tick  (o_div_tick[k]),
      .o_ratio_ack (o_ratio_ack[k])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
`timescale 1ns/1ps
module tb_clk_div_multi;

  localparam int NUM_CH  = 2;
  localparam int RATIO_W = 8;

  logic                      ref_clk = 1'b0;
  logic                      rst;
  logic [NUM_CH-1:0]         clk_en;
  logic [NUM_CH*RATIO_W-1:0] div_ratio;
  logic [NUM_CH-1:0]         ratio_load;
  logic [NUM_CH-1:0]         div_clk;
  logic [NUM_CH-1:0]         div_tick;
  logic [NUM_CH-1:0]         ratio_ack;

  int errors = 0;
  int checks = 0;

  // Reference model: per channel, active ratio, optional pending ratio,
  // whether a divided clock is running and the position inside its period.
  int m_act [NUM_CH];
  int m_pend[NUM_CH];
  bit m_pv  [NUM_CH];
  bit m_run [NUM_CH];
  int m_pos [NUM_CH];
  bit m_ack [NUM_CH];

  bit last_clk [NUM_CH];
  bit last_tick[NUM_CH];
  bit last_ack [NUM_CH];
  int ack_seen [NUM_CH];

  typedef struct {
    int ch;
    int ratio;
    int exp_per;
    int exp_hi;
  } vec_t;
  vec_t vecs[7];

  clk_div_multi #(
    .NUM_CH (NUM_CH),
    .RATIO_W(RATIO_W)
  ) dut (
    .i_ref_clk   (ref_clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .i_ratio_load(ratio_load),
    .o_div_clk   (div_clk),
    .o_div_tick  (div_tick),
    .o_ratio_ack (ratio_ack)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_act[k]  = 0;
      m_pend[k] = 0;
      m_pv[k]   = 1'b0;
      m_run[k]  = 1'b0;
      m_pos[k]  = 0;
      m_ack[k]  = 1'b0;
    end
  endtask

  // One reference edge worth of the divider rules, in plain integer arithmetic.
  task automatic model_step();
    int rin;
    int newr;
    bit ld;
    bit bnd;
    bit app;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        rin  = int'(div_ratio[k*RATIO_W +: RATIO_W]);
        ld   = ratio_load[k];
        bnd  = m_run[k] && (m_pos[k] == m_act[k] - 1);
        app  = m_run[k] ? (bnd && (m_pv[k] || ld)) : m_pv[k];
        newr = ld ? rin : m_pend[k];
        if (app) begin
          m_act[k] = newr;
          m_pv[k]  = 1'b0;
        end else if (ld) begin
          m_pend[k] = rin;
          m_pv[k]   = 1'b1;
        end
        m_ack[k] = app;
        if (!(clk_en[k] && m_act[k] >= 2)) begin
          m_run[k] = 1'b0;
          m_pos[k] = 0;
        end else if (!m_run[k] || app) begin
          m_run[k] = 1'b1;
          m_pos[k] = 0;
        end else begin
          m_pos[k] = (m_pos[k] + 1) % m_act[k];
        end
      end
    end
  endtask

  function automatic bit exp_clk(input int k, input bit ref_lvl);
    if (m_run[k]) return (m_pos[k] < (m_act[k] + 1) / 2);
    return ref_lvl;
  endfunction

  // Advance one reference cycle, checking every channel in both clock phases.
  task automatic cycle();
    @(posedge ref_clk);
    model_step();
    #2;
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("clk_hi_phase ch%0d", k), int'(div_clk[k]), int'(exp_clk(k, 1'b1)));
      check($sformatf("tick ch%0d", k), int'(div_tick[k]),
            int'(m_run[k] && (m_pos[k] == 0)));
      check($sformatf("ack ch%0d", k), int'(ratio_ack[k]), int'(m_ack[k]));
      last_clk[k]  = div_clk[k];
      last_tick[k] = div_tick[k];
      last_ack[k]  = ratio_ack[k];
      if (ratio_ack[k]) ack_seen[k]++;
    end
    @(negedge ref_clk);
    #2;
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("clk_lo_phase ch%0d", k), int'(div_clk[k]), int'(exp_clk(k, 1'b0)));
    end
  endtask

  task automatic load(input int k, input int r);
    div_ratio[k*RATIO_W +: RATIO_W] = RATIO_W'(r);
    ratio_load[k] = 1'b1;
    cycle();
    ratio_load[k] = 1'b0;
  endtask

  task automatic wait_ack(input int k, input int base, output int waited);
    waited = 0;
    while (ack_seen[k] == base && waited < 600) begin
      cycle();
      waited++;
    end
    check($sformatf("ack_within_bound ch%0d", k), int'(ack_seen[k] != base), 1);
  endtask

  // Period and high time, in reference cycles, from one tick to the next.
  task automatic measure(input int k, output int per, output int hi);
    int n;
    n = 0;
    while (!last_tick[k] && n < 600) begin
      cycle();
      n++;
    end
    per = 1;
    hi  = int'(last_clk[k]);
    n   = 0;
    forever begin
      cycle();
      n++;
      if (last_tick[k] || n >= 600) break;
      per++;
      hi += int'(last_clk[k]);
    end
    if (n >= 600) per = -1;
  endtask

  initial begin
    int per;
    int hi;
    int waited;
    int base0;
    int base1;

    vecs[0] = '{0, 4,   4,   2};
    vecs[1] = '{0, 5,   5,   3};
    vecs[2] = '{0, 255, 255, 128};
    vecs[3] = '{0, 2,   2,   1};
    vecs[4] = '{1, 7,   7,   4};
    vecs[5] = '{1, 3,   3,   2};
    vecs[6] = '{0, 6,   6,   3};

    for (int k = 0; k < NUM_CH; k++) ack_seen[k] = 0;
    rst        = 1'b1;
    clk_en     = '0;
    ratio_load = '0;
    div_ratio  = '0;
    model_reset();

    // Reset: passthrough, no tick, no ack.
    #2;
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("reset_clk ch%0d", k), int'(div_clk[k]), 0);
      check($sformatf("reset_tick ch%0d", k), int'(div_tick[k]), 0);
      check($sformatf("reset_ack ch%0d", k), int'(ratio_ack[k]), 0);
    end
    repeat (4) cycle();
    rst = 1'b0;
    repeat (4) cycle();

    // Table: load a ratio with enable high, then measure period and high time.
    for (int i = 0; i < 7; i++) begin
      clk_en[vecs[i].ch] = 1'b1;
      base0 = ack_seen[vecs[i].ch];
      load(vecs[i].ch, vecs[i].ratio);
      wait_ack(vecs[i].ch, base0, waited);
      measure(vecs[i].ch, per, hi);
      check($sformatf("vec%0d_period", i), per, vecs[i].exp_per);
      check($sformatf("vec%0d_high", i), hi, vecs[i].exp_hi);
    end

    // Ratio change mid-period: 4 -> 6 loaded at cnt==1, applied at the boundary.
    base0 = ack_seen[0];
    load(0, 4);
    wait_ack(0, base0, waited);
    measure(0, per, hi);
    cycle();
    base0 = ack_seen[0];
    load(0, 6);
    wait_ack(0, base0, waited);
    check("midchange_ack_latency", waited, 2);
    measure(0, per, hi);
    check("midchange_period", per, 6);
    check("midchange_high", hi, 3);

    // Two loads within one period: only the latest applies, single ack.
    base0 = ack_seen[0];
    load(0, 4);
    wait_ack(0, base0, waited);
    measure(0, per, hi);
    base0 = ack_seen[0];
    load(0, 6);
    load(0, 3);
    wait_ack(0, base0, waited);
    measure(0, per, hi);
    check("double_load_period", per, 3);
    check("double_load_high", hi, 2);
    repeat (6) cycle();
    check("double_load_ack_count", ack_seen[0] - base0, 1);

    // Ratios 0 and 1: bypass, each load still acknowledged.
    base0 = ack_seen[0];
    load(0, 0);
    wait_ack(0, base0, waited);
    repeat (3) cycle();
    check("ratio0_passthrough", int'(div_clk[0]), 0);
    load(0, 1);
    repeat (3) cycle();
    check("bypass_ack_count", ack_seen[0] - base0, 2);
    check("ratio1_passthrough", int'(div_clk[0]), 0);

    // Concurrent independent channels.
    base0 = ack_seen[0];
    base1 = ack_seen[1];
    div_ratio[0*RATIO_W +: RATIO_W] = 8'd3;
    div_ratio[1*RATIO_W +: RATIO_W] = 8'd7;
    ratio_load = 2'b11;
    cycle();
    ratio_load = '0;
    wait_ack(0, base0, waited);
    wait_ack(1, base1, waited);
    measure(0, per, hi);
    check("conc_ch0_period", per, 3);
    check("conc_ch0_high", hi, 2);
    measure(1, per, hi);
    check("conc_ch1_period", per, 7);
    check("conc_ch1_high", hi, 4);

    // Asynchronous reset mid-period, while ch1 is in its high phase.
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("async_rst_clk ch%0d", k), int'(div_clk[k]), int'(ref_clk));
      check($sformatf("async_rst_tick ch%0d", k), int'(div_tick[k]), 0);
    end
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    base0 = ack_seen[0];
    base1 = ack_seen[1];
    ratio_load = 2'b11;
    cycle();
    ratio_load = '0;
    wait_ack(0, base0, waited);
    check("restart_tick_at_ack", int'(last_tick[0]), 1);
    check("restart_high_at_ack", int'(last_clk[0]), 1);
    measure(0, per, hi);
    check("restart_ch0_period", per, 3);
    measure(1, per, hi);
    check("restart_ch1_period", per, 7);

    // Randomised enables and loads against the model.
    for (int n = 0; n < 2500; n++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 31) == 0) clk_en[k] = ~clk_en[k];
        if ($urandom_range(0, 7) == 0) begin
          ratio_load[k] = 1'b1;
          div_ratio[k*RATIO_W +: RATIO_W] = RATIO_W'($urandom_range(0, 12));
        end else begin
          ratio_load[k] = 1'b0;
        end
      end
      cycle();
    end
    ratio_load = '0;
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel integer clock divider, parametrised successor to the single-channel ClkDiv.
- Generates NUM_CH independent divided clocks from one reference clock. Each channel has its own ratio and enable.
- Adds glitch-free ratio change at period boundaries, a per-channel rising-edge tick, and a load/acknowledge handshake.
- Sits in the clocking subsystem and feeds UART/peripheral clock domains.

Parameters:
- NUM_CH, 2, number of independent divider channels.
- RATIO_W, 8, width of each ratio field (max ratio 2^RATIO_W-1).

Ports:
- i_ref_clk  in  1  reference clock; all logic on posedge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_clk_en  in  NUM_CH  per-channel enable.
- i_div_ratio  in  NUM_CH*RATIO_W  per-channel requested ratio; channel k at bits [k*RATIO_W +: RATIO_W].
- i_ratio_load  in  NUM_CH  one-cycle strobe that captures i_div_ratio for that channel.
- o_div_clk  out  NUM_CH  divided clock or ref passthrough.
- o_div_tick  out  NUM_CH  one-ref-cycle pulse marking start of each divided period.
- o_ratio_ack  out  NUM_CH  one-ref-cycle pulse when a loaded ratio becomes active.

Behaviour:
- Per-channel state: R_act (active ratio), R_pend plus pend_valid, counter cnt[RATIO_W-1:0], registered div_q.
- Reset (async): R_act=0, pend_valid=0, cnt=0, div_q=0, o_div_tick=0, o_ratio_ack=0. o_div_clk = i_ref_clk because R_act=0 selects bypass.
- Bypass mode when i_clk_en=0 or R_act<=1: o_div_clk = i_ref_clk (combinational mux). cnt and div_q are held at 0, and o_div_tick stays 0.
- Divide mode when i_clk_en=1 and R_act>=2:
  - cnt counts 0..R_act-1 and wraps, so the period is exactly R_act ref cycles.
  - High phase H = (R_act+1)>>1, i.e. ceil: odd ratios are high one cycle longer.
  - div_q=1 while cnt<H, else 0. o_div_clk = div_q.
  - o_div_tick=1 in the cycle where cnt==0.
- Enable rising: the first ref edge with en=1 sets cnt=0 and div_q=1 (tick asserted). Enable falling: cnt and div_q clear on the next edge, and the output returns to passthrough.
- Load handshake:
  - An i_ratio_load pulse writes R_pend and sets pend_valid.
  - A second load before application overwrites R_pend (latest wins).
- Apply point:
  - In divide mode, the edge where cnt==R_act-1 (period boundary).
  - In bypass, the next ref edge after the load.
  - At apply: R_act<=R_pend, pend_valid<=0, cnt<=0, o_ratio_ack pulses for 1 cycle.
- Load coincident with boundary: the incoming i_div_ratio is applied directly at that edge (bypasses R_pend) and ack pulses in the same cycle.
- No runt pulses: in divide mode, every high phase lasts exactly H of the ratio then active and every low phase lasts R-H. Passthrough↔divide switching happens only at an apply point or an enable edge, and the mux glitch there is accepted.
- Ratios 0 and 1 are both treated as bypass, and the ack still pulses.
- Channels are fully independent and share no counters.
- Widths: all ratio arithmetic is done in RATIO_W bits. R_act-1 is never evaluated when R_act<2.

Decomposition:
- Package clk_div_pkg holds RATIO_W default, BYPASS_MAX=1, and a function half_high(ratio) returning (ratio+1)>>1.
- Sub-module clk_div_ch implements one channel (counter, pending register, handshake, mux).
- clk_div_multi is a generate loop over NUM_CH instances plus bus slicing.

Test Plan:
- Reset with i_rst=1 and en=0 → o_div_clk toggles with i_ref_clk (10ns), tick=0, ack=0. After deassert, still passthrough.
- ch0: load 4, en=1 → ack 1 cycle. o_div_clk period 40ns, high 20ns; tick every 4th ref cycle, aligned to the rising edge.
- ch0: load 5 → period 50ns, high 30ns, low 20ns. Load 255 → period 2550ns, high 1280ns.
- ch0 running at 4, load 6 at cnt==1 → the current 40ns period completes, ack at the boundary, next period 60ns/high 30ns. No high or low phase shorter than 20ns is observed.
- ch0 load 0, then load 1 → o_div_clk equals i_ref_clk (10ns period) and ack pulses each time. Two loads (6 then 3) within one period → only 3 applied, single ack.
- ch0=3 and ch1=7 concurrently → periods 30ns and 70ns, independent. Assert i_rst mid-period → both outputs go to passthrough immediately. After release plus load, both restart from cnt=0.
